regfile_sb: RTL

Parametrised, scoreboarded general register file for the decode stage of the pipelined MIPS core. Provides NRD combinational read ports, one write port driven from the writeback stage, and a per-register pending-write counter. The counter lets decode detect reads of registers with an outstanding writer and raise a stall without a separate hazard unit. Optional writeback-to-decode bypass removes the one-cycle write/read gap.

---
 rtl/regfile_sb_if.sv | 28 ++
 rtl/regfile_sb.sv | 86 ++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the scoreboarded register file.
// The master modport is the pipeline side; the slave modport is the register file itself.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  issue_en;
    logic [ADDR_W-1:0]     issue_addr;
    logic                  issue_ready;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  sb_err;

    modport master (
        output rd_addr, issue_en, issue_addr, wr_en, wr_addr, wr_data,
        input  rd_data, rd_busy, issue_ready, sb_err
    );

    modport slave (
        input  rd_addr, issue_en, issue_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_busy, issue_ready, sb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Scoreboarded register file: NRD combinational reads (0 cycles), writes/counters land next edge; writeback bypass under GRF_BYPASS_EN.
// Backpressure: issue_ready drops while the destination's pending counter is saturated; decode holds the issue.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] PMAX = '1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PEND_W-1:0] cnt [DEPTH];
    logic              sb_err_q;

    logic              issue_acc;
    logic              retire;
    logic              same_reg;
    logic [NRD*DATA_W-1:0] rd_data_c;
    logic [NRD-1:0]        rd_busy_c;
    logic [ADDR_W-1:0]     ra;

    assign bus.issue_ready = (bus.issue_addr == '0) || (cnt[bus.issue_addr] != PMAX);
    assign issue_acc       = bus.issue_en && bus.issue_ready && (bus.issue_addr != '0);
    assign retire          = bus.wr_en && (bus.wr_addr != '0);
    assign same_reg        = issue_acc && retire && (bus.issue_addr == bus.wr_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (retire) begin
                mem[bus.wr_addr] <= bus.wr_data;
                if (cnt[bus.wr_addr] == '0) begin
                    sb_err_q <= 1'b1;
                end
            end
            // Issue and retire on one register cancel, except an underflowing retire leaves the new issue pending.
            if (same_reg) begin
                if (cnt[bus.wr_addr] == '0) begin
                    cnt[bus.wr_addr] <= PEND_W'(1);
                end
            end else begin
                if (issue_acc) begin
                    cnt[bus.issue_addr] <= cnt[bus.issue_addr] + 1'b1;
                end
                if (retire && (cnt[bus.wr_addr] != '0)) begin
                    cnt[bus.wr_addr] <= cnt[bus.wr_addr] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
            if (ra != '0) begin
                rd_data_c[i*DATA_W +: DATA_W] = mem[ra];
                rd_busy_c[i]                  = (cnt[ra] != '0);
`ifdef GRF_BYPASS_EN
                // The retiring write is forwarded; busy reflects the counter after this retire.
                if (retire && (ra == bus.wr_addr)) begin
                    rd_data_c[i*DATA_W +: DATA_W] = bus.wr_data;
                    rd_busy_c[i] = (cnt[ra] > PEND_W'(1)) ||
                                   (issue_acc && (bus.issue_addr == ra));
                end
`endif
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;
    assign bus.sb_err  = sb_err_q;
endmodule
